// File: rtl/regfile_pkg.sv
// Shared types and helpers for the clearable multi-port register file.
package regfile_pkg;

    // Clear sequencer state encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // True when addr lies inside the populated window lo..hi (inclusive).
    function automatic logic in_range(input int addr, input int lo, input int hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    // LSB of port idx inside a flat packed bus of width-bit slices.
    function automatic int port_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_clr_if.sv
// Bus bundle for regfile_clr: write port, clear control, error flag and
// flat-packed read address/data buses (port i at [i*width +: width]).
interface regfile_clr_if #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int nrd        = 4
);
    logic                         CLR;
    logic                         BUSY;
    logic                         WE;
    logic [addr_width-1:0]        ADDR_IN;
    logic [data_width-1:0]        D_IN;
    logic [nrd*addr_width-1:0]    ADDR_RD;
    logic [nrd*data_width-1:0]    D_OUT;
    logic                         ERR;
    logic                         ERR_CLR;

    modport master (
        output CLR, WE, ADDR_IN, D_IN, ADDR_RD, ERR_CLR,
        input  BUSY, D_OUT, ERR
    );

    modport slave (
        input  CLR, WE, ADDR_IN, D_IN, ADDR_RD, ERR_CLR,
        output BUSY, D_OUT, ERR
    );
endinterface

// File: rtl/regfile_clr_rdport.sv
// One read port: range check, init_val substitution while clearing or when
// the address is outside lo..hi, and an optional output register that
// bypasses a same-cycle accepted write to the address being read.
module regfile_clr_rdport
    import regfile_pkg::*;
#(
    parameter int                    addr_width = 5,
    parameter int                    data_width = 32,
    parameter int                    lo         = 0,
    parameter int                    hi         = 31,
    parameter int                    rd_reg     = 1,
    parameter logic [data_width-1:0] init_val   = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  busy,
    input  logic                  wr_acc,
    input  logic [addr_width-1:0] addr_in,
    input  logic [data_width-1:0] d_in,
    input  logic [addr_width-1:0] addr_rd,
    input  logic [data_width-1:0] arr_data,
    output logic [data_width-1:0] d_out
);

    logic                  hit;
    logic [data_width-1:0] rd_val;

    assign hit    = in_range(32'(addr_rd), lo, hi);
    assign rd_val = (busy || !hit) ? init_val : arr_data;

    generate
        if (rd_reg != 0) begin : g_reg
            logic [data_width-1:0] q;

            // Capture the array value, or the incoming write data on an address match.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    q <= init_val;
                end else if (wr_acc && (addr_in == addr_rd)) begin
                    q <= d_in;
                end else begin
                    q <= rd_val;
                end
            end

            // The register may hold pre-clear data on the first CLEAR cycle, so mask it.
            assign d_out = busy ? init_val : q;
        end else begin : g_comb
            logic unused_comb;
            assign unused_comb = ^{CLK, RST_N, wr_acc, addr_in, d_in};
            assign d_out       = rd_val;
        end
    endgenerate

endmodule

// File: rtl/regfile_clr.sv
// Parametrised multi-port register file with a hardware clear sequencer.
// After reset, or on CLR, every entry lo..hi is written with init_val, one
// per cycle; writes outside lo..hi are dropped and raise a sticky ERR.
module regfile_clr
    import regfile_pkg::*;
#(
    parameter int                    addr_width = 5,
    parameter int                    data_width = 32,
    parameter int                    lo         = 0,
    parameter int                    hi         = 31,
    parameter int                    nrd        = 4,
    parameter int                    rd_reg     = 1,
    parameter logic [data_width-1:0] init_val   = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    regfile_clr_if.slave  bus
);

    localparam int DEPTH = 1 << addr_width;

    state_t                state;
    logic [addr_width-1:0] ptr;
    logic                  err_q;
    logic                  busy;
    logic                  idle_wr;
    logic                  addr_ok;
    logic                  wr_acc;
    logic                  wr_bad;

    // Storage is deliberately not reset; the clear sequencer defines content.
    logic [data_width-1:0] arr [DEPTH];

    assign busy    = (state == CLEAR);
    assign idle_wr = (state == IDLE) && !bus.CLR && bus.WE;
    assign addr_ok = in_range(32'(bus.ADDR_IN), lo, hi);
    assign wr_acc  = idle_wr && addr_ok;
    assign wr_bad  = idle_wr && !addr_ok;

    // Clear sequencer: walk ptr from lo to hi, then return to IDLE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= CLEAR;
            ptr   <= addr_width'(lo);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.CLR) begin
                        state <= CLEAR;
                        ptr   <= addr_width'(lo);
                    end
                end
                CLEAR: begin
                    if (ptr == addr_width'(hi)) begin
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + addr_width'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Array write: clear sequencer has priority, then accepted user writes.
    always_ff @(posedge CLK) begin
        if (busy) begin
            arr[ptr] <= init_val;
        end else if (wr_acc) begin
            arr[bus.ADDR_IN] <= bus.D_IN;
        end
    end

    // Sticky out-of-range flag; a new set beats a simultaneous ERR_CLR, frozen while clearing.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if (!busy) begin
            if (wr_bad) begin
                err_q <= 1'b1;
            end else if (bus.ERR_CLR) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.BUSY = busy;
    assign bus.ERR  = err_q;

    generate
        for (genvar i = 0; i < nrd; i++) begin : g_rd
            logic [addr_width-1:0] ra;
            assign ra = bus.ADDR_RD[port_lsb(i, addr_width) +: addr_width];

            regfile_clr_rdport #(
                .addr_width (addr_width),
                .data_width (data_width),
                .lo         (lo),
                .hi         (hi),
                .rd_reg     (rd_reg),
                .init_val   (init_val)
            ) u_rdport (
                .CLK      (CLK),
                .RST_N    (RST_N),
                .busy     (busy),
                .wr_acc   (wr_acc),
                .addr_in  (bus.ADDR_IN),
                .d_in     (bus.D_IN),
                .addr_rd  (ra),
                .arr_data (arr[ra]),
                .d_out    (bus.D_OUT[port_lsb(i, data_width) +: data_width])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_clr.sv
// Scoreboard bench for regfile_clr: three configurations share one clock.
//   A: lo=0 hi=31 nrd=4 registered reads, init 0
//   B: lo=4 hi=11 nrd=4 registered reads, init 0xFFFF0000
//   C: lo=0 hi=31 nrd=1 combinational reads, init 0
module tb_regfile_clr;

    localparam int K_BUSY = 0;
    localparam int K_ERR  = 1;
    localparam int K_DOUT = 2;  // + port index

    logic CLK = 1'b0;
    logic rst_a = 1'b0;
    logic rst_bc = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        int          cyc;
        int          dut;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    regfile_clr_if #(.addr_width(5), .data_width(32), .nrd(4)) ia ();
    regfile_clr_if #(.addr_width(5), .data_width(32), .nrd(4)) ib ();
    regfile_clr_if #(.addr_width(5), .data_width(32), .nrd(1)) ic ();

    regfile_clr #(.addr_width(5), .data_width(32), .lo(0), .hi(31), .nrd(4),
                  .rd_reg(1), .init_val(32'h0000_0000))
        u_a (.CLK(CLK), .RST_N(rst_a), .bus(ia));
    regfile_clr #(.addr_width(5), .data_width(32), .lo(4), .hi(11), .nrd(4),
                  .rd_reg(1), .init_val(32'hFFFF_0000))
        u_b (.CLK(CLK), .RST_N(rst_bc), .bus(ib));
    regfile_clr #(.addr_width(5), .data_width(32), .lo(0), .hi(31), .nrd(1),
                  .rd_reg(0), .init_val(32'h0000_0000))
        u_c (.CLK(CLK), .RST_N(rst_bc), .bus(ic));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    function automatic logic [31:0] get_act(input int dut, input int kind);
        logic [31:0] v;
        v = 32'hx;
        case (dut)
            0: v = (kind == K_BUSY) ? 32'(ia.BUSY) : (kind == K_ERR) ? 32'(ia.ERR)
                                    : ia.D_OUT[(kind-K_DOUT)*32 +: 32];
            1: v = (kind == K_BUSY) ? 32'(ib.BUSY) : (kind == K_ERR) ? 32'(ib.ERR)
                                    : ib.D_OUT[(kind-K_DOUT)*32 +: 32];
            default: v = (kind == K_BUSY) ? 32'(ic.BUSY) : (kind == K_ERR) ? 32'(ic.ERR)
                                          : ic.D_OUT;
        endcase
        return v;
    endfunction

    // Monitor: at each falling edge, compare every expectation due this cycle.
    always @(negedge CLK) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                act = get_act(sb[i].dut, sb[i].kind);
                n_chk++;
                if (act === sb[i].exp) n_pass++;
                else $display("FAIL %s (dut%0d cyc %0d): got %h want %h",
                              sb[i].name, sb[i].dut, cyc, act, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_chk++;
                $display("FAIL %s (dut%0d): expectation for cyc %0d never sampled",
                         sb[i].name, sb[i].dut, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_at(input int dut, input int kind, input int dc,
                             input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cyc + dc;
        e.dut  = dut;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd_a(input int p, input int a);
        ia.ADDR_RD[p*5 +: 5] = 5'(a);
    endtask

    task automatic rd_b(input int p, input int a);
        ib.ADDR_RD[p*5 +: 5] = 5'(a);
    endtask

    initial begin
        int bound;
        {ia.CLR, ia.WE, ia.ADDR_IN, ia.D_IN, ia.ADDR_RD, ia.ERR_CLR} = '0;
        {ib.CLR, ib.WE, ib.ADDR_IN, ib.D_IN, ib.ADDR_RD, ib.ERR_CLR} = '0;
        {ic.CLR, ic.WE, ic.ADDR_IN, ic.D_IN, ic.ADDR_RD, ic.ERR_CLR} = '0;

        // Reset state
        tick(); tick(); tick();
        expect_at(0, K_BUSY, 0, 32'd1, "rst_busy_a");
        expect_at(0, K_ERR, 0, 32'd0, "rst_err_a");
        expect_at(0, K_DOUT+0, 0, 32'h0, "rst_dout_a");
        expect_at(1, K_DOUT+0, 0, 32'hFFFF_0000, "rst_dout_b");
        expect_at(1, K_BUSY, 0, 32'd1, "rst_busy_b");
        tick();
        rst_a = 1'b1;
        rst_bc = 1'b1;

        // Initial clear length: 32 cycles for A/C, 8 for B
        for (int i = 0; i < 32; i++) expect_at(0, K_BUSY, i, 32'd1, "clr_busy_a");
        expect_at(0, K_BUSY, 32, 32'd0, "clr_done_a");
        expect_at(2, K_BUSY, 32, 32'd0, "clr_done_c");
        expect_at(1, K_BUSY, 7, 32'd1, "clr_last_b");
        expect_at(1, K_BUSY, 8, 32'd0, "clr_done_b");
        repeat (32) tick();

        // All addresses of A read back as 0 across four ports
        for (int s = 0; s < 8; s++) begin
            for (int p = 0; p < 4; p++) begin
                rd_a(p, 4*s + p);
                expect_at(0, K_DOUT+p, 1, 32'h0, "post_clr_read_a");
            end
            tick();
        end

        // Bypass: write addr 7 while port 2 reads it, port 0 reads addr 6
        ia.WE = 1'b1; ia.ADDR_IN = 5'd7; ia.D_IN = 32'hDEAD_BEEF;
        rd_a(2, 7); rd_a(0, 6);
        expect_at(0, K_DOUT+2, 1, 32'hDEAD_BEEF, "bypass_p2");
        expect_at(0, K_DOUT+0, 1, 32'h0, "bypass_p0_other");
        tick();
        ia.WE = 1'b0;
        expect_at(0, K_DOUT+2, 1, 32'hDEAD_BEEF, "array_p2");
        tick();

        // CLR together with WE: clear wins, 32 busy cycles, CLR mid-clear ignored
        ia.WE = 1'b1; ia.ADDR_IN = 5'd3; ia.D_IN = 32'h55;
        tick();
        ia.WE = 1'b0; rd_a(1, 3);
        expect_at(0, K_DOUT+1, 1, 32'h55, "wr55_rd");
        tick();
        ia.CLR = 1'b1; ia.WE = 1'b1; ia.ADDR_IN = 5'd5; ia.D_IN = 32'hAA;
        expect_at(0, K_BUSY, 0, 32'd0, "clr_req_idle");
        for (int i = 1; i <= 32; i++) expect_at(0, K_BUSY, i, 32'd1, "clr_req_busy");
        expect_at(0, K_BUSY, 33, 32'd0, "clr_req_done");
        expect_at(0, K_DOUT+1, 1, 32'h0, "clr_dout_forced");
        tick();
        ia.CLR = 1'b0; ia.WE = 1'b0;
        repeat (4) tick();
        ia.CLR = 1'b1;
        tick();
        ia.CLR = 1'b0;
        repeat (27) tick();
        rd_a(1, 3); rd_a(3, 5);
        expect_at(0, K_DOUT+1, 1, 32'h0, "after_clr_addr3");
        expect_at(0, K_DOUT+3, 1, 32'h0, "after_clr_addr5");
        tick();

        // Reset pulse at clear cycle 10 restarts the full 32-cycle clear
        ia.CLR = 1'b1;
        tick();
        ia.CLR = 1'b0;
        repeat (10) tick();
        rst_a = 1'b0;
        expect_at(0, K_BUSY, 0, 32'd1, "midrst_busy");
        tick();
        rst_a = 1'b1;
        for (int i = 0; i < 32; i++) expect_at(0, K_BUSY, i, 32'd1, "midrst_clr_busy");
        expect_at(0, K_BUSY, 32, 32'd0, "midrst_clr_done");
        repeat (32) tick();

        // B: out-of-range write, sticky ERR, set beats ERR_CLR
        ib.WE = 1'b1; ib.ADDR_IN = 5'd4; ib.D_IN = 32'h11;
        tick();
        ib.ADDR_IN = 5'd12; ib.D_IN = 32'h99;
        rd_b(0, 12); rd_b(1, 4);
        expect_at(1, K_ERR, 0, 32'd0, "err_before");
        expect_at(1, K_ERR, 1, 32'd1, "err_set");
        expect_at(1, K_DOUT+0, 1, 32'hFFFF_0000, "oor_read_12");
        expect_at(1, K_DOUT+1, 1, 32'h11, "inrange_read_4");
        tick();
        ib.ADDR_IN = 5'd3; ib.D_IN = 32'h77; ib.ERR_CLR = 1'b1;
        rd_b(2, 3);
        expect_at(1, K_ERR, 1, 32'd1, "err_set_wins");
        expect_at(1, K_DOUT+2, 1, 32'hFFFF_0000, "oor_read_3");
        tick();
        ib.WE = 1'b0;
        rd_b(3, 11);
        expect_at(1, K_ERR, 1, 32'd0, "err_cleared");
        expect_at(1, K_DOUT+3, 1, 32'hFFFF_0000, "hi_entry_cleared");
        tick();
        ib.ERR_CLR = 1'b0;
        ib.WE = 1'b1; ib.ADDR_IN = 5'd11; ib.D_IN = 32'h22;
        expect_at(1, K_DOUT+3, 1, 32'h22, "bypass_b_hi");
        expect_at(1, K_ERR, 1, 32'd0, "err_stays_clear");
        tick();
        ib.WE = 1'b0;
        tick();

        // C: combinational read, write visible the cycle after WE
        ic.WE = 1'b1; ic.ADDR_IN = 5'd9; ic.D_IN = 32'h1234; ic.ADDR_RD = 5'd9;
        expect_at(2, K_DOUT, 0, 32'h0, "comb_same_cycle");
        expect_at(2, K_DOUT, 1, 32'h1234, "comb_next_cycle");
        tick();
        ic.WE = 1'b0;
        tick();

        // Drain the scoreboard with a bounded wait
        bound = 0;
        while (sb.size() != 0 && bound < 50) begin
            tick();
            bound++;
        end
        if (sb.size() != 0) begin
            n_chk += sb.size();
            $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
